hazard_ctrl: RTL and testbench

- Producer side of the forwarding path: tracks in-flight register writes through E/M/W and publishes each stage's write enable, destination and Tnew.
- E/M-stage forwarding multiplexers consume these outputs.
- Also decides when forwarding cannot cover a D-stage read (Tnew > Tuse) and inserts a stall and bubble.
- Owns the mult/div busy window.
- Sits between the D-stage decoder and the pipeline registers.

---
 rtl/hazard_ctrl.sv | 130 +++++++++++++
 tb/tb_hazard_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: tracks in-flight GRF writes through E/M/W, raises load-use and mult/div stalls.
// Optional macro HAZARD_STATS_EN adds the stall_count and md_stall outputs.
module hazard_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  D_Rs,
    input  logic [4:0]  D_Rt,
    input  logic [1:0]  D_TuseRs,
    input  logic [1:0]  D_TuseRt,
    input  logic        D_GRFWE,
    input  logic [4:0]  D_Addr,
    input  logic [1:0]  D_Tnew,
    input  logic        D_MDUse,
    input  logic [1:0]  E_MDStart,
    output logic        Stall,
    output logic        E_Flush,
    output logic        E_GRFWE,
    output logic        M_GRFWE,
    output logic        W_GRFWE,
    output logic [4:0]  E_Addr,
    output logic [4:0]  M_Addr,
    output logic [4:0]  W_Addr,
    output logic [1:0]  E_Tnew,
    output logic [1:0]  M_Tnew,
    output logic [1:0]  W_Tnew
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0] stall_count,
    output logic        md_stall
`endif
);

    localparam logic [3:0] MULT_LD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LD  = 4'(DIV_CYCLES);

    logic       vld_p0, vld_p1, vld_p2;
    logic [4:0] addr_p0, addr_p1, addr_p2;
    logic [1:0] tnew_p0, tnew_p1, tnew_p2;
    logic [3:0] md_cnt;
    logic       stall_rs, stall_rt, stall_md;

    function automatic logic [1:0] tnew_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    function automatic logic src_hazard(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic       we_e,
        input logic [4:0] addr_e,
        input logic [1:0] tnew_e,
        input logic       we_m,
        input logic [4:0] addr_m,
        input logic [1:0] tnew_m
    );
        return (tuse != 2'd3) && (src != 5'd0) &&
               ((we_e && addr_e == src && tnew_e > tuse) ||
                (we_m && addr_m == src && tnew_m > tuse));
    endfunction

    assign stall_rs = src_hazard(D_Rs, D_TuseRs, vld_p0, addr_p0, tnew_p0,
                                 vld_p1, addr_p1, tnew_p1);
    assign stall_rt = src_hazard(D_Rt, D_TuseRt, vld_p0, addr_p0, tnew_p0,
                                 vld_p1, addr_p1, tnew_p1);
    assign stall_md = D_MDUse && (md_cnt != 4'd0 || E_MDStart == 2'b01 || E_MDStart == 2'b10);
    assign Stall    = stall_rs | stall_rt | stall_md;
    assign E_Flush  = Stall;

    // D -> E (p0), E -> M (p1), M -> W (p2)
    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
            addr_p0 <= '0;
            addr_p1 <= '0;
            addr_p2 <= '0;
            tnew_p0 <= '0;
            tnew_p1 <= '0;
            tnew_p2 <= '0;
        end else begin
            vld_p0  <= Stall ? 1'b0 : D_GRFWE;
            addr_p0 <= Stall ? 5'd0 : D_Addr;
            tnew_p0 <= Stall ? 2'd0 : D_Tnew;
            vld_p1  <= vld_p0;
            addr_p1 <= addr_p0;
            tnew_p1 <= tnew_dec(tnew_p0);
            vld_p2  <= vld_p1;
            addr_p2 <= addr_p1;
            tnew_p2 <= tnew_dec(tnew_p1);
        end
    end

    // A start in E always reloads, even while busy
    always_ff @(posedge clk) begin
        if (!reset)
            md_cnt <= '0;
        else if (E_MDStart == 2'b01)
            md_cnt <= MULT_LD;
        else if (E_MDStart == 2'b10)
            md_cnt <= DIV_LD;
        else if (md_cnt != 4'd0)
            md_cnt <= md_cnt - 4'd1;
    end

    assign E_GRFWE = vld_p0;
    assign M_GRFWE = vld_p1;
    assign W_GRFWE = vld_p2;
    assign E_Addr  = addr_p0;
    assign M_Addr  = addr_p1;
    assign W_Addr  = addr_p2;
    assign E_Tnew  = tnew_p0;
    assign M_Tnew  = tnew_p1;
    assign W_Tnew  = tnew_p2;

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset)
            stall_count <= '0;
        else if (Stall)
            stall_count <= stall_count + 32'd1;
    end

    assign md_stall = stall_md & ~(stall_rs | stall_rt);
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed pipeline scenarios plus random stimulus
// checked against a history-based reference model of in-flight writes.
module tb_hazard_ctrl;

    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] D_Rs, D_Rt, D_Addr;
    logic [1:0] D_TuseRs, D_TuseRt, D_Tnew, E_MDStart;
    logic       D_GRFWE, D_MDUse;
    logic       Stall, E_Flush, E_GRFWE, M_GRFWE, W_GRFWE;
    logic [4:0] E_Addr, M_Addr, W_Addr;
    logic [1:0] E_Tnew, M_Tnew, W_Tnew;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_count;
    logic        md_stall;
`endif

    int errors = 0;
    int checks = 0;

    hazard_ctrl #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
        .clk(clk), .reset(reset),
        .D_Rs(D_Rs), .D_Rt(D_Rt), .D_TuseRs(D_TuseRs), .D_TuseRt(D_TuseRt),
        .D_GRFWE(D_GRFWE), .D_Addr(D_Addr), .D_Tnew(D_Tnew), .D_MDUse(D_MDUse),
        .E_MDStart(E_MDStart), .Stall(Stall), .E_Flush(E_Flush),
        .E_GRFWE(E_GRFWE), .M_GRFWE(M_GRFWE), .W_GRFWE(W_GRFWE),
        .E_Addr(E_Addr), .M_Addr(M_Addr), .W_Addr(W_Addr),
        .E_Tnew(E_Tnew), .M_Tnew(M_Tnew), .W_Tnew(W_Tnew)
`ifdef HAZARD_STATS_EN
        , .stall_count(stall_count), .md_stall(md_stall)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: every instruction that entered E is logged by the cycle it entered.
    // During cycle c, stage k (0=E,1=M,2=W) holds the record that entered at c-k, with
    // Tnew reduced by k (floored at 0). Reset invalidates all records older than vfrom.
    logic       rec_we[int];
    logic [4:0] rec_addr[int];
    logic [1:0] rec_tnew[int];
    int cyc = 0;
    int vfrom = 0;
    int md_start = -1000;
    int md_len = 0;

    function automatic logic [7:0] model_stage(input int k);
        int rc;
        int t;
        rc = cyc - k;
        if (rc < vfrom || !rec_we.exists(rc)) return 8'd0;
        t = int'(rec_tnew[rc]) - k;
        if (t < 0) t = 0;
        return {rec_we[rc], rec_addr[rc], 2'(t)};
    endfunction

    function automatic bit model_src(input logic [4:0] r, input logic [1:0] tuse);
        logic [7:0] s;
        if (tuse == 2'd3 || r == 5'd0) return 1'b0;
        for (int k = 0; k < 2; k++) begin
            s = model_stage(k);
            if (s[7] && s[6:2] == r && s[1:0] > tuse) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit model_stall();
        bit md_busy;
        md_busy = (E_MDStart == 2'b01) || (E_MDStart == 2'b10) ||
                  (cyc > md_start && cyc <= md_start + md_len);
        return model_src(D_Rs, D_TuseRs) || model_src(D_Rt, D_TuseRt) || (D_MDUse && md_busy);
    endfunction

    task automatic tick();
        bit st;
        @(posedge clk);
        if (!reset) begin
            vfrom    = cyc + 2;
            md_start = -1000;
        end else begin
            st = model_stall();
            rec_we[cyc+1]   = st ? 1'b0 : D_GRFWE;
            rec_addr[cyc+1] = st ? 5'd0 : D_Addr;
            rec_tnew[cyc+1] = st ? 2'd0 : D_Tnew;
            if (E_MDStart == 2'b01) begin md_start = cyc; md_len = MULT_CYCLES; end
            if (E_MDStart == 2'b10) begin md_start = cyc; md_len = DIV_CYCLES; end
        end
        cyc++;
        #1;
    endtask

    task automatic set_d(input logic we, input logic [4:0] addr, input logic [1:0] tnew,
                         input logic [4:0] rs, input logic [1:0] tuse_rs,
                         input logic [4:0] rt, input logic [1:0] tuse_rt, input logic mduse);
        D_GRFWE = we; D_Addr = addr; D_Tnew = tnew;
        D_Rs = rs; D_TuseRs = tuse_rs; D_Rt = rt; D_TuseRt = tuse_rt; D_MDUse = mduse;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        E_MDStart = 2'b00;
        set_d(0, 0, 0, 0, 3, 0, 3, 0);
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if ({Stall, E_Flush, E_GRFWE, M_GRFWE, W_GRFWE, E_Addr, M_Addr, W_Addr, E_Tnew, M_Tnew, W_Tnew} !== 26'd0) begin
            errors++;
            $display("FAIL reset_outputs: got E=%0d/%0d/%0d M=%0d/%0d/%0d W=%0d/%0d/%0d stall=%0d, want all 0",
                     E_GRFWE, E_Addr, E_Tnew, M_GRFWE, M_Addr, M_Tnew, W_GRFWE, W_Addr, W_Tnew, Stall);
        end
        tick();
    endtask

    task automatic test_load_alu();
        do_reset();
        set_d(1, 8, 2, 0, 3, 0, 3, 0);   // lw $t0
        tick();
        set_d(1, 9, 1, 8, 1, 0, 3, 0);   // add $t1, $t0, ...
        @(negedge clk);
        checks++;
        if (Stall !== 1'b1 || E_Flush !== 1'b1) begin
            errors++; $display("FAIL load_alu_stall1: got stall=%0d flush=%0d want 1/1", Stall, E_Flush);
        end
        tick();
        @(negedge clk);
        checks++;
        if (Stall !== 1'b0 || E_GRFWE !== 1'b0 || M_Addr !== 5'd8 || M_Tnew !== 2'd1) begin
            errors++;
            $display("FAIL load_alu_bubble: got stall=%0d E_GRFWE=%0d M_Addr=%0d M_Tnew=%0d want 0/0/8/1",
                     Stall, E_GRFWE, M_Addr, M_Tnew);
        end
        tick();
        set_d(0, 0, 0, 0, 3, 0, 3, 0);
        @(negedge clk);
        checks++;
        if (E_GRFWE !== 1'b1 || E_Addr !== 5'd9 || E_Tnew !== 2'd1 || W_Addr !== 5'd8 || W_Tnew !== 2'd0) begin
            errors++;
            $display("FAIL load_alu_proceed: got E=%0d/%0d/%0d W_Addr=%0d W_Tnew=%0d want 1/9/1 8 0",
                     E_GRFWE, E_Addr, E_Tnew, W_Addr, W_Tnew);
        end
        tick();
    endtask

    task automatic test_load_branch();
        int n;
        do_reset();
        set_d(1, 8, 2, 0, 3, 0, 3, 0);
        tick();
        set_d(0, 0, 0, 8, 0, 0, 3, 0);   // beq $t0, $0
        n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (Stall !== 1'b1) break;
            n++;
            tick();
        end
        checks++;
        if (n != 2) begin
            errors++; $display("FAIL load_branch_stalls: got %0d stall cycles want 2", n);
        end
        tick();
    endtask

    task automatic test_zero_reg();
        do_reset();
        set_d(1, 0, 2, 0, 3, 0, 3, 0);   // write to $0 with load-like Tnew
        tick();
        set_d(0, 0, 0, 0, 0, 0, 0, 0);   // beq $0, $0
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (Stall !== 1'b0) begin
                errors++; $display("FAIL zero_reg_stall cycle %0d: got %0d want 0", i, Stall);
            end
            tick();
        end
    endtask

    task automatic test_md_busy();
        int n;
        do_reset();
        E_MDStart = 2'b10;
        set_d(1, 2, 1, 0, 3, 0, 3, 1);   // mflo held in D
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            checks++;
            if (Stall !== model_stall()) begin
                errors++; $display("FAIL md_busy_model cycle %0d: got %0d want %0d", i, Stall, model_stall());
            end
            if (Stall !== 1'b1) break;
            n++;
            tick();
            E_MDStart = 2'b00;
        end
        checks++;
        if (n != DIV_CYCLES + 1) begin
            errors++; $display("FAIL md_busy_len: got %0d stall cycles want %0d", n, DIV_CYCLES + 1);
        end
        tick();
        @(negedge clk);
        checks++;
        if (E_GRFWE !== 1'b1 || E_Addr !== 5'd2) begin
            errors++; $display("FAIL md_release_issue: got E=%0d/%0d want 1/2", E_GRFWE, E_Addr);
        end
        tick();
    endtask

    task automatic test_reset_mid_div();
        do_reset();
        E_MDStart = 2'b10;
        set_d(1, 3, 1, 0, 3, 0, 3, 0);
        tick();
        E_MDStart = 2'b00;
        set_d(1, 4, 2, 0, 3, 0, 3, 0);
        for (int i = 0; i < 4; i++) tick();   // counter now 6
        set_d(1, 5, 1, 0, 3, 0, 3, 1);       // mflo
        @(negedge clk);
        checks++;
        if (Stall !== 1'b1 || M_GRFWE !== 1'b1) begin
            errors++; $display("FAIL mid_div_busy: got stall=%0d M_GRFWE=%0d want 1/1", Stall, M_GRFWE);
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({Stall, E_GRFWE, M_GRFWE, W_GRFWE, E_Addr, M_Addr, W_Addr, E_Tnew, M_Tnew, W_Tnew} !== 25'd0) begin
            errors++;
            $display("FAIL mid_div_reset: got stall=%0d E=%0d/%0d M=%0d/%0d W=%0d/%0d want all 0",
                     Stall, E_GRFWE, E_Addr, M_GRFWE, M_Addr, W_GRFWE, W_Addr);
        end
        tick();
        set_d(0, 0, 0, 0, 3, 0, 3, 0);
        @(negedge clk);
        checks++;
        if (E_GRFWE !== 1'b1 || E_Addr !== 5'd5) begin
            errors++; $display("FAIL mid_div_mflo: got E=%0d/%0d want 1/5", E_GRFWE, E_Addr);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_d(1, 5'(10 + i), 1, 5'(20 + i), 1, 5'(21 + i), 1, 0);
            @(negedge clk);
            checks++;
            if (Stall !== 1'b0) begin
                errors++; $display("FAIL b2b_stall %0d: got %0d want 0", i, Stall);
            end
            if (i >= 3) begin
                checks++;
                if (E_Tnew !== 2'd1 || M_Tnew !== 2'd0 || W_Tnew !== 2'd0 ||
                    E_Addr !== 5'(9 + i) || M_Addr !== 5'(8 + i) || W_Addr !== 5'(7 + i)) begin
                    errors++;
                    $display("FAIL b2b_tnew %0d: got Tnew %0d/%0d/%0d Addr %0d/%0d/%0d want 1/0/0 %0d/%0d/%0d",
                             i, E_Tnew, M_Tnew, W_Tnew, E_Addr, M_Addr, W_Addr, 9 + i, 8 + i, 7 + i);
                end
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_e, exp_m, exp_w;
        bit exp_st;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 49) != 0);
            set_d($urandom_range(0, 1), 5'($urandom_range(0, 5)), 2'($urandom_range(0, 2)),
                  5'($urandom_range(0, 5)), 2'($urandom_range(0, 3)),
                  5'($urandom_range(0, 5)), 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) == 0));
            E_MDStart = ($urandom_range(0, 11) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            @(negedge clk);
            exp_st = model_stall();
            exp_e = model_stage(0);
            exp_m = model_stage(1);
            exp_w = model_stage(2);
            checks++;
            if (Stall !== exp_st || E_Flush !== exp_st) begin
                errors++; $display("FAIL rnd_stall %0d: got %0d/%0d want %0d", i, Stall, E_Flush, exp_st);
            end
            checks++;
            if ({E_GRFWE, E_Addr, E_Tnew} !== exp_e) begin
                errors++; $display("FAIL rnd_e %0d: got %h want %h", i, {E_GRFWE, E_Addr, E_Tnew}, exp_e);
            end
            checks++;
            if ({M_GRFWE, M_Addr, M_Tnew} !== exp_m) begin
                errors++; $display("FAIL rnd_m %0d: got %h want %h", i, {M_GRFWE, M_Addr, M_Tnew}, exp_m);
            end
            checks++;
            if ({W_GRFWE, W_Addr, W_Tnew} !== exp_w) begin
                errors++; $display("FAIL rnd_w %0d: got %h want %h", i, {W_GRFWE, W_Addr, W_Tnew}, exp_w);
            end
            tick();
        end
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        E_MDStart = 2'b00;
        set_d(0, 0, 0, 0, 3, 0, 3, 0);
        #1;
        test_reset();
        test_load_alu();
        test_load_branch();
        test_zero_reg();
        test_md_busy();
        test_reset_mid_div();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
